// File: rtl/keypad_scanner.sv
// 3x4 matrix keypad scanner for the alarm clock: column strobe, per-frame row decode,
// frame-level debounce FSM and a valid/ack handshake toward the clock control logic.
module keypad_scanner #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [2:0] columns,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held,
  output logic       overrun
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1) + 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_N = CW'(DEBOUNCE);

  typedef enum logic [1:0] {S_IDLE, S_DEB, S_HELD} state_t;

  logic [DW-1:0] r_dwell;
  logic [1:0]    r_col;
  logic [1:0]    r_acc_n;
  logic [3:0]    r_acc_code;
  logic          r_frm_vld;
  logic [1:0]    r_frm_n;
  logic [3:0]    r_frm_code;
  state_t        r_state;
  logic [3:0]    r_cand;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_rcnt;
  logic [3:0]    r_key_code;
  logic          r_key_valid;
  logic          r_key_held;
  logic          r_overrun;

  logic [3:0] w_low;
  logic [2:0] w_nsamp;
  logic [2:0] w_sum;
  logic [1:0] w_n_tot;
  logic [1:0] w_row;
  logic [3:0] w_code;
  logic       w_last;
  logic       w_frm_key;
  logic       w_frm_none;
  logic       w_accept;
  logic [3:0] w_acc_code;

  function automatic logic [3:0] f_decode(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case (row)
      2'd0:    code = (col == 2'd0) ? 4'd11 : ((col == 2'd1) ? 4'd0 : 4'd10);
      2'd1:    code = 4'd9 - {2'b00, col};
      2'd2:    code = 4'd6 - {2'b00, col};
      default: code = 4'd3 - {2'b00, col};
    endcase
    return code;
  endfunction

  assign w_low   = ~rows;
  assign w_nsamp = {2'b00, w_low[0]} + {2'b00, w_low[1]} + {2'b00, w_low[2]} + {2'b00, w_low[3]};
  assign w_sum   = {1'b0, r_acc_n} + w_nsamp;
  // Low-row count only needs to distinguish none / one / several across the frame.
  assign w_n_tot = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
  assign w_last  = (r_dwell == DWELL_LAST);

  always_comb begin
    w_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_low[i]) w_row = 2'(i);
    end
  end

  assign w_code = (r_acc_n == 2'd0) ? f_decode(w_row, r_col) : r_acc_code;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dwell    <= '0;
      r_col      <= 2'd0;
      r_acc_n    <= 2'd0;
      r_acc_code <= 4'd0;
      r_frm_vld  <= 1'b0;
      r_frm_n    <= 2'd0;
      r_frm_code <= 4'd0;
    end else begin
      r_frm_vld <= 1'b0;
      if (w_last) begin
        r_dwell <= '0;
        if (r_col == 2'd2) begin
          r_col      <= 2'd0;
          r_frm_vld  <= 1'b1;
          r_frm_n    <= w_n_tot;
          r_frm_code <= w_code;
          r_acc_n    <= 2'd0;
          r_acc_code <= 4'd0;
        end else begin
          r_col      <= r_col + 2'd1;
          r_acc_n    <= w_n_tot;
          r_acc_code <= w_code;
        end
      end else begin
        r_dwell <= r_dwell + 1'b1;
      end
    end
  end

  assign columns    = ~(3'b001 << r_col);
  assign w_frm_key  = r_frm_vld && (r_frm_n == 2'd1);
  assign w_frm_none = r_frm_vld && (r_frm_n == 2'd0);
  assign w_acc_code = (r_state == S_IDLE) ? r_frm_code : r_cand;

  always_comb begin
    w_accept = 1'b0;
    if (w_frm_key) begin
      if (r_state == S_IDLE && DEBOUNCE == 1) w_accept = 1'b1;
      else if (r_state == S_DEB && r_frm_code == r_cand && (r_cnt + 1'b1) >= DEB_N) w_accept = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cand      <= 4'd0;
      r_cnt       <= '0;
      r_rcnt      <= '0;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (r_frm_vld) begin
        case (r_state)
          S_IDLE: begin
            if (w_frm_key) begin
              r_cand  <= r_frm_code;
              r_cnt   <= CW'(1);
              r_rcnt  <= '0;
              r_state <= (DEBOUNCE == 1) ? S_HELD : S_DEB;
            end
          end
          S_DEB: begin
            if (w_frm_key && r_frm_code == r_cand) begin
              if (r_cnt < DEB_N) r_cnt <= r_cnt + 1'b1;
              if (w_accept) begin
                r_state <= S_HELD;
                r_rcnt  <= '0;
              end
            end else begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
            end
          end
          S_HELD: begin
            if (w_frm_none) begin
              if ((r_rcnt + 1'b1) >= DEB_N) begin
                r_state    <= S_IDLE;
                r_rcnt     <= '0;
                r_cnt      <= '0;
                r_key_held <= 1'b0;
              end else begin
                r_rcnt <= r_rcnt + 1'b1;
              end
            end else begin
              r_rcnt <= '0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
      // An ack landing on the accept cycle consumes the old key, not the new one.
      if (w_accept) begin
        r_key_code  <= w_acc_code;
        r_key_valid <= 1'b1;
        r_key_held  <= 1'b1;
        r_overrun   <= r_key_valid && !key_ack;
      end else if (key_ack && r_key_valid) begin
        r_key_valid <= 1'b0;
        r_overrun   <= 1'b0;
      end
    end
  end

  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model driving the rows, frame-level reference
// model of the debounce/handshake rules, directed scenarios followed by random key traffic.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;
  localparam int FRAME    = 3 * SCAN_DIV;
  localparam int NOKEY    = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rows;
  logic [2:0] columns;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack = 1'b0;
  logic       key_held;
  logic       overrun;

  int ka = NOKEY;
  int kb = NOKEY;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int t = 0;
  int m_state = 0;
  int m_cand = 0;
  int m_cnt = 0;
  int m_rcnt = 0;
  bit pend = 0;
  int pend_n = 0;
  int pend_code = 0;
  int exp_valid = 0;
  int exp_code = 0;
  int exp_held = 0;
  int exp_ovr = 0;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk      (clk),
    .reset    (reset),
    .rows     (rows),
    .columns  (columns),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ack  (key_ack),
    .key_held (key_held),
    .overrun  (overrun)
  );

  function automatic int key_row(input int k);
    case (k)
      1, 2, 3: return 3;
      4, 5, 6: return 2;
      7, 8, 9: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int key_col(input int k);
    case (k)
      3, 6, 9, 11: return 0;
      0, 2, 5, 8:  return 1;
      default:     return 2;
    endcase
  endfunction

  always_comb begin
    rows = 4'hF;
    if (ka != NOKEY && columns[key_col(ka)] == 1'b0) rows[key_row(ka)] = 1'b0;
    if (kb != NOKEY && columns[key_col(kb)] == 1'b0) rows[key_row(kb)] = 1'b0;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s t=%0d got=%0d expected=%0d", tag, t, got, exp);
    end
  endtask

  task automatic model_edge();
    bit accept;
    int n;
    accept = 0;
    if (reset) begin
      t = 0; m_state = 0; m_cand = 0; m_cnt = 0; m_rcnt = 0; pend = 0;
      exp_valid = 0; exp_code = 0; exp_held = 0; exp_ovr = 0;
    end else begin
      t++;
      if (pend) begin
        pend = 0;
        case (m_state)
          0: if (pend_n == 1) begin
               m_cand = pend_code; m_cnt = 1;
               if (m_cnt >= DEBOUNCE) begin accept = 1; m_state = 2; m_rcnt = 0; end
               else m_state = 1;
             end
          1: if (pend_n == 1 && pend_code == m_cand) begin
               m_cnt++;
               if (m_cnt >= DEBOUNCE) begin accept = 1; m_state = 2; m_rcnt = 0; end
             end else begin
               m_state = 0; m_cnt = 0;
             end
          default: if (pend_n == 0) begin
               m_rcnt++;
               if (m_rcnt >= DEBOUNCE) begin m_state = 0; m_rcnt = 0; exp_held = 0; end
             end else begin
               m_rcnt = 0;
             end
        endcase
      end
      if (accept) begin
        exp_code = m_cand;
        exp_ovr = (exp_valid == 1 && !key_ack) ? 1 : 0;
        exp_valid = 1;
        exp_held = 1;
      end else if (key_ack && exp_valid == 1) begin
        exp_valid = 0;
        exp_ovr = 0;
      end
      if (t % FRAME == 0) begin
        n = 0;
        if (ka != NOKEY) n++;
        if (kb != NOKEY && kb != ka) n++;
        pend = 1;
        pend_n = n;
        pend_code = (ka != NOKEY) ? ka : kb;
      end
    end
  endtask

  task automatic check_all();
    logic [2:0] exp_cols;
    exp_cols = ~(3'b001 << ((t / SCAN_DIV) % 3));
    chk("columns", int'(columns), int'(exp_cols));
    chk("key_valid", int'(key_valid), exp_valid);
    chk("key_code", int'(key_code), exp_code);
    chk("key_held", int'(key_held), exp_held);
    chk("overrun", int'(overrun), exp_ovr);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic frame(input int a, input int b, input bit ack_first);
    ka = a;
    kb = b;
    for (int i = 0; i < FRAME; i++) begin
      key_ack = ack_first && (i == 0);
      tick();
    end
    key_ack = 1'b0;
  endtask

  task automatic frames(input int n, input int a);
    repeat (n) frame(a, NOKEY, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    key_ack = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0d got=timeout expected=finish", t);
    $fatal(1, "watchdog");
  end

  initial begin
    int p, len, a, b;

    // 1: reset state and first-press latency
    do_reset();
    chk("rst_columns", int'(columns), 6);
    chk("rst_valid", int'(key_valid), 0);
    frames(3, 5);
    chk("lat36_valid", int'(key_valid), 0);
    ka = 5;
    tick();
    chk("lat37_valid", int'(key_valid), 1);
    chk("lat37_code", int'(key_code), 5);
    chk("lat37_held", int'(key_held), 1);
    repeat (FRAME - 1) tick();
    frames(3, NOKEY);
    frame(NOKEY, NOKEY, 1'b1);
    chk("t1_ack_valid", int'(key_valid), 0);

    // 2: short press rejected, full-length press accepted
    frames(2, 10);
    frames(2, NOKEY);
    chk("t2_short_valid", int'(key_valid), 0);
    frames(3, 11);
    frame(NOKEY, NOKEY, 1'b0);
    chk("t2_valid", int'(key_valid), 1);
    chk("t2_code", int'(key_code), 11);
    frames(3, NOKEY);
    frame(NOKEY, NOKEY, 1'b1);

    // 3: long hold gives a single report, then release
    frames(3, 7);
    frames(10, 7);
    chk("t3_held", int'(key_held), 1);
    chk("t3_code", int'(key_code), 7);
    frames(3, NOKEY);
    frame(NOKEY, NOKEY, 1'b1);
    chk("t3_held_rel", int'(key_held), 0);
    chk("t3_valid", int'(key_valid), 0);

    // 4: second key before ack raises overrun; ack clears both
    frames(3, 3);
    frames(3, NOKEY);
    frames(3, 9);
    frame(NOKEY, NOKEY, 1'b0);
    chk("t4_code", int'(key_code), 9);
    chk("t4_overrun", int'(overrun), 1);
    frame(NOKEY, NOKEY, 1'b1);
    chk("t4_ack_valid", int'(key_valid), 0);
    chk("t4_ack_overrun", int'(overrun), 0);
    frames(2, NOKEY);

    // 5: alternating keys and simultaneous keys never accepted
    for (int i = 0; i < 8; i++) frame((i % 2 == 0) ? 2 : 6, NOKEY, 1'b0);
    repeat (4) frame(2, 6, 1'b0);
    frames(2, NOKEY);
    chk("t5_valid", int'(key_valid), 0);

    // 6: reset mid-debounce, then ack coinciding with a new accept
    frames(2, 8);
    ka = 8;
    repeat (5) tick();
    do_reset();
    chk("t6_columns", int'(columns), 6);
    chk("t6_valid", int'(key_valid), 0);
    frames(3, 8);
    chk("t6_fresh_valid", int'(key_valid), 0);
    frame(8, NOKEY, 1'b0);
    chk("t6_code8", int'(key_code), 8);
    frames(3, NOKEY);
    frames(3, 4);
    ka = NOKEY;
    key_ack = 1'b1;
    tick();
    key_ack = 1'b0;
    chk("t6_same_valid", int'(key_valid), 1);
    chk("t6_same_code", int'(key_code), 4);
    chk("t6_same_ovr", int'(overrun), 0);
    repeat (FRAME - 1) tick();
    frames(3, NOKEY);
    frame(NOKEY, NOKEY, 1'b1);

    // random key traffic with random acks and occasional mid-frame resets
    for (int r = 0; r < 60; r++) begin
      p = int'($urandom_range(0, 9));
      len = int'($urandom_range(1, 5));
      a = NOKEY;
      b = NOKEY;
      if (p == 3) begin
        a = int'($urandom_range(0, 11));
        b = (a + 1 + int'($urandom_range(0, 10))) % 12;
      end else if (p >= 4 && p <= 8) begin
        a = int'($urandom_range(0, 11));
      end
      if (p == 9) begin
        repeat ($urandom_range(1, FRAME - 1)) tick();
        do_reset();
      end else begin
        repeat (len) begin
          ka = a;
          kb = b;
          for (int i = 0; i < FRAME; i++) begin
            key_ack = ($urandom_range(0, 7) == 0);
            tick();
          end
          key_ack = 1'b0;
        end
      end
    end
    frames(4, NOKEY);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
